// File: rtl/mem_init_gen_pkg.sv
// -----------------------------------------------------------------------------
// mem_init_pkg
// Shared types and the fill-pattern function for the memory initialiser.
//   state_t      : FSM states of mem_init_gen (VERIFY is only reachable when
//                  MEM_INIT_VERIFY_EN is defined).
//   fill_mode_t  : encoding of the 2-bit mode input.
//   pattern()    : f(mode, seed, i), computed at PAT_W bits; callers
//                  truncate to their word width (modulo 2**DATA_W).
// -----------------------------------------------------------------------------
package mem_init_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        VERIFY = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        FM_OFFSET = 2'd0,   // i + seed  (seed = 0 gives the ARC4 identity)
        FM_CONST  = 2'd1,   // seed
        FM_DESC   = 2'd2,   // DEPTH-1-i
        FM_XOR    = 2'd3    // i ^ seed
    } fill_mode_t;

    // Working width of the pattern arithmetic. Low bits of +, - and ^ only
    // depend on low operand bits, so truncating the result afterwards gives
    // the same answer as computing at the word width directly.
    localparam int PAT_W = 32;

    function automatic logic [PAT_W-1:0] pattern(
        input fill_mode_t       mode,
        input logic [PAT_W-1:0] seed,
        input logic [PAT_W-1:0] idx,
        input logic [PAT_W-1:0] depth
    );
        logic [PAT_W-1:0] res;
        case (mode)
            FM_OFFSET: res = idx + seed;
            FM_CONST:  res = seed;
            FM_DESC:   res = depth - PAT_W'(1) - idx;
            default:   res = idx ^ seed;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mem_init_gen_if.sv
// -----------------------------------------------------------------------------
// mem_init_gen_if
// Start handshake plus memory write bus of the S-array initialiser.
//   en, mode, seed       : start request and fill operands (controller side)
//   rdy, done            : idle indication and one-cycle completion pulse
//   addr, wrdata, wren   : synchronous single-port RAM write port
//   rddata, err          : RAM read data and sticky verify error
//                          (present only when MEM_INIT_VERIFY_EN is defined)
// Modports:
//   master : the initialiser itself
//   slave  : the controller / memory side
// -----------------------------------------------------------------------------
interface mem_init_gen_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
);

    logic              en;
    logic [1:0]        mode;
    logic [DATA_W-1:0] seed;
    logic              rdy;
    logic              done;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wrdata;
    logic              wren;
`ifdef MEM_INIT_VERIFY_EN
    logic [DATA_W-1:0] rddata;
    logic              err;
`endif

`ifdef MEM_INIT_VERIFY_EN
    modport master (
        input  en, mode, seed, rddata,
        output rdy, done, addr, wrdata, wren, err
    );

    modport slave (
        output en, mode, seed, rddata,
        input  rdy, done, addr, wrdata, wren, err
    );
`else
    modport master (
        input  en, mode, seed,
        output rdy, done, addr, wrdata, wren
    );

    modport slave (
        output en, mode, seed,
        input  rdy, done, addr, wrdata, wren
    );
`endif

endinterface

// File: rtl/mem_init_gen_pattern.sv
// -----------------------------------------------------------------------------
// mem_init_pattern
// Combinational fill-pattern generator f(mode, seed, i).
//   mode_i : latched fill mode
//   seed_i : latched seed operand
//   idx_i  : word index (zero-extended or truncated to DATA_W as needed)
//   data_o : pattern value, modulo 2**DATA_W
// -----------------------------------------------------------------------------
module mem_init_pattern
    import mem_init_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  fill_mode_t        mode_i,
    input  logic [DATA_W-1:0] seed_i,
    input  logic [ADDR_W-1:0] idx_i,
    output logic [DATA_W-1:0] data_o
);

    always_comb begin
        data_o = DATA_W'(pattern(mode_i, PAT_W'(seed_i), PAT_W'(idx_i), PAT_W'(DEPTH)));
    end

endmodule

// File: rtl/mem_init_gen.sv
// -----------------------------------------------------------------------------
// mem_init_gen
// Fills a synchronous single-port RAM of DEPTH words, one write per clock,
// with a pattern selected at start time. Drop-in successor of the ARC4
// S-array init stage (same en/rdy start, same addr/wrdata/wren bus).
//
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : mem_init_gen_if.master (en/mode/seed in, rdy/done/addr/wrdata/wren
//          out; rddata in and err out with MEM_INIT_VERIFY_EN)
//
// Build option:
//   MEM_INIT_VERIFY_EN : after FILL, read the RAM back for DEPTH cycles
//                        (plus one drain cycle for the RAM read latency)
//                        and raise a sticky err on any mismatch. done/rdy
//                        are held off until the read-back finishes.
//
// All outputs are registered except wrdata, which is f(mode_q, seed_q, i_q).
// -----------------------------------------------------------------------------
module mem_init_gen
    import mem_init_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic           clk,
    input  logic           rst,
    mem_init_gen_if.master bus
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] i_q, i_d;
    fill_mode_t        mode_q, mode_d;
    logic [DATA_W-1:0] seed_q, seed_d;
    logic              rdy_q, rdy_d;
    logic              done_q, done_d;
    logic              wren_q, wren_d;
    logic [DATA_W-1:0] wrdata;
`ifdef MEM_INIT_VERIFY_EN
    logic              drain_q, drain_d;
    logic              err_q, err_d;
    logic              vld_p1;
    logic [DATA_W-1:0] exp_p1;
`endif

    mem_init_pattern #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_pattern (
        .mode_i (mode_q),
        .seed_i (seed_q),
        .idx_i  (i_q),
        .data_o (wrdata)
    );

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        mode_d  = mode_q;
        seed_d  = seed_q;
        rdy_d   = rdy_q;
        done_d  = 1'b0;
        wren_d  = wren_q;
`ifdef MEM_INIT_VERIFY_EN
        drain_d = drain_q;
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: begin
                rdy_d  = 1'b1;
                wren_d = 1'b0;
                if (bus.en) begin
                    state_d = FILL;
                    mode_d  = fill_mode_t'(bus.mode);
                    seed_d  = bus.seed;
                    i_d     = '0;
                    rdy_d   = 1'b0;
                    wren_d  = 1'b1;
`ifdef MEM_INIT_VERIFY_EN
                    drain_d = 1'b0;
                    err_d   = 1'b0;
`endif
                end
            end

            FILL: begin
                if (i_q == LAST) begin
                    i_d    = '0;
                    wren_d = 1'b0;
`ifdef MEM_INIT_VERIFY_EN
                    state_d = VERIFY;
                    drain_d = 1'b0;
`else
                    state_d = IDLE;
                    rdy_d   = 1'b1;
                    done_d  = 1'b1;
`endif
                end else begin
                    i_d = i_q + ADDR_W'(1);
                end
            end

`ifdef MEM_INIT_VERIFY_EN
            VERIFY: begin
                // The address sweep stops at LAST; one extra drain cycle
                // lets the last read word come back and be compared.
                if (drain_q) begin
                    state_d = IDLE;
                    i_d     = '0;
                    drain_d = 1'b0;
                    rdy_d   = 1'b1;
                    done_d  = 1'b1;
                end else if (i_q == LAST) begin
                    drain_d = 1'b1;
                end else begin
                    i_d = i_q + ADDR_W'(1);
                end
                if (vld_p1 && (bus.rddata != exp_p1)) begin
                    err_d = 1'b1;
                end
            end
`endif

            default: begin
                state_d = IDLE;
                rdy_d   = 1'b1;
                wren_d  = 1'b0;
            end
        endcase
    end

    // mode/seed are reset too so that wrdata reads 0 straight out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            i_q     <= '0;
            mode_q  <= FM_OFFSET;
            seed_q  <= '0;
            rdy_q   <= 1'b1;
            done_q  <= 1'b0;
            wren_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            mode_q  <= mode_d;
            seed_q  <= seed_d;
            rdy_q   <= rdy_d;
            done_q  <= done_d;
            wren_q  <= wren_d;
        end
    end

`ifdef MEM_INIT_VERIFY_EN
    // Stage p1: expected word for the address presented last cycle, lined up
    // with the RAM's one-cycle read latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            drain_q <= 1'b0;
            err_q   <= 1'b0;
            vld_p1  <= 1'b0;
        end else begin
            drain_q <= drain_d;
            err_q   <= err_d;
            vld_p1  <= (state_q == VERIFY) && !drain_q;
        end
    end

    always_ff @(posedge clk) begin
        exp_p1 <= wrdata;
    end

    assign bus.err = err_q;
`endif

    assign bus.rdy    = rdy_q;
    assign bus.done   = done_q;
    assign bus.addr   = i_q;
    assign bus.wrdata = wrdata;
    assign bus.wren   = wren_q;

endmodule
